// File: rtl/unit_sched.sv
// Round-robin unit scheduler: examines one unit per cycle for a free, ready and
// unmasked target, holds the grant until tx_done, and tracks outstanding work.
module unit_sched #(
   parameter  int N_UNITS = 4,
   parameter  int TIMEOUT = 4096,
   localparam int UW      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
   localparam int CW      = $clog2(N_UNITS + 1),
   localparam int WW      = $clog2(TIMEOUT + 1)
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               req,
   input  logic               tx_done,
   input  logic [N_UNITS-1:0] unit_ready,
   input  logic [N_UNITS-1:0] unit_tx_mask,
   input  logic [N_UNITS-1:0] unit_result,
   output logic               grant,
   output logic [UW-1:0]      grant_unit,
   output logic [N_UNITS-1:0] busy,
   output logic [CW-1:0]      n_busy,
   output logic               idle,
   output logic               err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_GRANT  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [UW-1:0]      ptr_q, ptr_d;
   logic [UW-1:0]      gu_q, gu_d;
   logic               grant_q, grant_d;
   logic [N_UNITS-1:0] busy_q, busy_d;
   logic [CW-1:0]      nbusy_q;
   logic               idle_q;
   logic               err_q, err_d;
   logic [WW-1:0]      wd_q, wd_d;
   logic               elig;
   logic [1:0]         rst_sync_q;
   logic               rst_n_int;

   function automatic logic [UW-1:0] next_idx(input logic [UW-1:0] i);
      if (i == UW'(N_UNITS - 1)) begin
         return '0;
      end else begin
         return i + UW'(1);
      end
   endfunction

   function automatic logic [CW-1:0] popcnt(input logic [N_UNITS-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N_UNITS; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Reset asserts immediately but releases on a clock edge so the FSM leaves reset cleanly.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   // Next-state logic; a result clears busy first so a same-cycle tx_done set wins.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gu_d    = gu_q;
      grant_d = grant_q;
      busy_d  = busy_q & ~unit_result;
      err_d   = err_q;
      wd_d    = '0;
      elig    = unit_ready[ptr_q] & ~unit_tx_mask[ptr_q] & ~busy_q[ptr_q];

      if (|(unit_result & ~busy_q)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end

      case (state_q)
         S_IDLE: begin
            grant_d = 1'b0;
            if (tx_done) begin
               err_d = 1'b1;
            end else begin
               err_d = err_d;
            end
            if (req) begin
               state_d = S_SEARCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEARCH: begin
            if (tx_done || (wd_q == WW'(TIMEOUT - 1))) begin
               err_d = 1'b1;
            end else begin
               err_d = err_d;
            end
            if (!req) begin
               state_d = S_IDLE;
            end else if (elig) begin
               gu_d    = ptr_q;
               grant_d = 1'b1;
               state_d = S_GRANT;
            end else begin
               ptr_d = next_idx(ptr_q);
               wd_d  = (wd_q == WW'(TIMEOUT - 1)) ? wd_q : wd_q + WW'(1);
            end
         end
         S_GRANT: begin
            if (tx_done) begin
               busy_d[gu_q] = 1'b1;
               ptr_d        = next_idx(gu_q);
               grant_d      = 1'b0;
               state_d      = S_IDLE;
            end else begin
               grant_d = 1'b1;
            end
         end
         default: begin
            grant_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; idle and n_busy track the registered busy vector.
   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gu_q    <= '0;
         grant_q <= 1'b0;
         busy_q  <= '0;
         nbusy_q <= '0;
         idle_q  <= 1'b1;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gu_q    <= gu_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         nbusy_q <= popcnt(busy_q);
         idle_q  <= (state_d == S_IDLE) && (popcnt(busy_q) == CW'(0));
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   assign grant      = grant_q;
   assign grant_unit = gu_q;
   assign busy       = busy_q;
   assign n_busy     = nbusy_q;
   assign idle       = idle_q;
   assign err        = err_q;

endmodule

// File: tb/tb_unit_sched.sv
// Directed self-checking bench for unit_sched with N_UNITS=4, TIMEOUT=16.
module tb_unit_sched;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b1;
   logic       req = 1'b0;
   logic       tx_done = 1'b0;
   logic [3:0] unit_ready = 4'b0000;
   logic [3:0] unit_tx_mask = 4'b0000;
   logic [3:0] unit_result = 4'b0000;
   logic       grant;
   logic [1:0] grant_unit;
   logic [3:0] busy;
   logic [2:0] n_busy;
   logic       idle;
   logic       err;

   int checks = 0;
   int failures = 0;

   unit_sched #(.N_UNITS(4), .TIMEOUT(16)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .req(req), .tx_done(tx_done),
      .unit_ready(unit_ready), .unit_tx_mask(unit_tx_mask), .unit_result(unit_result),
      .grant(grant), .grant_unit(grant_unit), .busy(busy), .n_busy(n_busy),
      .idle(idle), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      req = 1'b0; tx_done = 1'b0; unit_result = 4'b0000;
      unit_ready = 4'b0000; unit_tx_mask = 4'b0000;
      RESET_N = 1'b0;
      step(); step();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_err", 32'(err), 32'd0);
      RESET_N = 1'b1;
      step(); step(); step();
   endtask

   // one request with the unit at the scan pointer eligible
   task automatic round(input string tag, input logic [1:0] exp_u);
      req = 1'b1;
      step();
      chk({tag, "_grant_lat1"}, 32'(grant), 32'd0);
      step();
      chk({tag, "_grant"}, 32'(grant), 32'd1);
      chk({tag, "_unit"}, 32'(grant_unit), 32'(exp_u));
      req = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk({tag, "_drop"}, 32'(grant), 32'd0);
   endtask

   initial begin
      int n;
      // Section A: reset values, three rounds, result clearing, set-wins
      do_reset();
      chk("rst_nbusy", 32'(n_busy), 32'd0);
      chk("rst_gu", 32'(grant_unit), 32'd0);
      unit_ready = 4'b1111;
      round("r0", 2'd0);
      chk("r0_busy", 32'(busy), 32'h1);
      round("r1", 2'd1);
      round("r2", 2'd2);
      chk("r2_busy", 32'(busy), 32'h7);
      step();
      chk("r2_nbusy", 32'(n_busy), 32'd3);
      chk("r2_idle", 32'(idle), 32'd0);
      chk("r2_err", 32'(err), 32'd0);
      unit_result = 4'b0101;
      step();
      unit_result = 4'b0000;
      chk("res_busy", 32'(busy), 32'h2);
      step();
      chk("res_nbusy", 32'(n_busy), 32'd1);
      chk("res_err", 32'(err), 32'd0);
      unit_tx_mask = 4'b1000;
      req = 1'b1;
      step(); step();
      chk("sw_grant_pre", 32'(grant), 32'd0);
      step();
      chk("sw_grant", 32'(grant), 32'd1);
      chk("sw_unit", 32'(grant_unit), 32'd0);
      req = 1'b0; tx_done = 1'b1; unit_result = 4'b0001;
      step();
      tx_done = 1'b0; unit_result = 4'b0000;
      chk("setwins_busy", 32'(busy), 32'h3);

      // Section B: skipping masked/not-ready units, mask change in GRANT, restart point
      do_reset();
      unit_ready = 4'b1111;
      round("b0", 2'd0);
      unit_ready = 4'b1011; unit_tx_mask = 4'b0010;
      req = 1'b1;
      step(); step(); step();
      chk("skip_grant_pre", 32'(grant), 32'd0);
      step();
      chk("skip_grant", 32'(grant), 32'd1);
      chk("skip_unit", 32'(grant_unit), 32'd3);
      req = 1'b0; unit_tx_mask = 4'b1000;
      step();
      chk("mask_keep_grant", 32'(grant), 32'd1);
      chk("mask_keep_unit", 32'(grant_unit), 32'd3);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("skip_busy", 32'(busy), 32'h9);
      unit_tx_mask = 4'b0000; unit_ready = 4'b1111;
      req = 1'b1;
      step(); step();
      chk("wrap_grant_pre", 32'(grant), 32'd0);
      step();
      chk("wrap_grant", 32'(grant), 32'd1);
      chk("wrap_unit", 32'(grant_unit), 32'd1);
      req = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("b_err", 32'(err), 32'd0);

      // Section C: watchdog with every unit busy, then recovery by a result
      do_reset();
      unit_ready = 4'b1111;
      round("c0", 2'd0);
      round("c1", 2'd1);
      round("c2", 2'd2);
      round("c3", 2'd3);
      chk("c_busy", 32'(busy), 32'hF);
      req = 1'b1;
      for (int i = 0; i < 16; i++) step();
      chk("wd_err_pre", 32'(err), 32'd0);
      chk("wd_grant_pre", 32'(grant), 32'd0);
      step();
      chk("wd_err", 32'(err), 32'd1);
      chk("wd_grant", 32'(grant), 32'd0);
      unit_result = 4'b0100;
      step();
      unit_result = 4'b0000;
      n = 0;
      while (!grant && n < 4) begin
         step();
         n++;
      end
      chk("wd_recover_grant", 32'(grant), 32'd1);
      chk("wd_recover_unit", 32'(grant_unit), 32'd2);
      chk("wd_err_sticky", 32'(err), 32'd1);
      req = 1'b0; tx_done = 1'b1;
      step();
      tx_done = 1'b0;

      // Section D: req withdrawn in SEARCH, reset during GRANT, stray tx_done
      do_reset();
      unit_ready = 4'b1111;
      round("d0", 2'd0);
      unit_ready = 4'b0000;
      req = 1'b1;
      step(); step();
      req = 1'b0;
      step();
      chk("withdraw_grant", 32'(grant), 32'd0);
      unit_ready = 4'b1111;
      req = 1'b1;
      step(); step();
      chk("retain_grant", 32'(grant), 32'd1);
      chk("retain_unit", 32'(grant_unit), 32'd2);
      req = 1'b0;
      RESET_N = 1'b0;
      #1;
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_idle", 32'(idle), 32'd1);
      step();
      RESET_N = 1'b1;
      step(); step(); step();
      chk("stray_err_pre", 32'(err), 32'd0);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("stray_err", 32'(err), 32'd1);
      chk("stray_grant", 32'(grant), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
